// File: rtl/riscv_regfile.sv
// riscv_regfile: architectural integer register file plus write-pending scoreboard.
// Each register x1..x31 keeps its value and a saturating pending counter.
// The counter goes up on issue-time locks and down on completion writes.
// x0 is hardwired to zero and is never locked.
// Every output comes from a flop; there is no write-to-read bypass.

// One register entry: data word, pending counter and an over/underflow pulse.
module riscv_regfile_entry #(
    parameter int IDX    = 1,
    parameter int P      = 2,
    parameter int PEND_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_flush,
    input  logic [P-1:0]         i_lock_en,
    input  logic [P-1:0][4:0]    i_lock,
    input  logic [P-1:0]         i_write_en,
    input  logic [P-1:0][4:0]    i_write,
    input  logic [P-1:0][31:0]   i_write_data,
    output logic [31:0]          o_value,
    output logic                 o_locked,
    output logic                 o_err
);
    localparam int              SW   = PEND_W + 2;
    localparam logic [4:0]      ADDR = 5'(IDX);
    localparam logic [PEND_W-1:0] MAXC = '1;

    logic [31:0]       r_value;
    logic [PEND_W-1:0] r_cnt;

    logic [SW-1:0]     w_l;
    logic [SW-1:0]     w_w;
    logic              w_wr_hit;
    logic [31:0]       w_wr_data;
    logic signed [SW-1:0] w_next;
    logic              w_under;
    logic              w_over;
    logic [PEND_W-1:0] w_cnt_nxt;

    // Count lock/write hits on this register; the highest-index writing port wins the data.
    always_comb begin
        w_l       = '0;
        w_w       = '0;
        w_wr_hit  = 1'b0;
        w_wr_data = r_value;
        for (int p = 0; p < P; p++) begin
            if (i_lock_en[p] && (i_lock[p] == ADDR))
                w_l = w_l + SW'(1);
            if (i_write_en[p] && (i_write[p] == ADDR)) begin
                w_w       = w_w + SW'(1);
                w_wr_hit  = 1'b1;
                w_wr_data = i_write_data[p];
            end
        end
    end

    // Signed next count, saturated at both ends; a flush discards all adjustments.
    always_comb begin
        w_next    = $signed({2'b00, r_cnt}) + $signed(w_l) - $signed(w_w);
        w_under   = (w_next < 0);
        w_over    = (w_next > $signed({2'b00, MAXC}));
        w_cnt_nxt = w_next[PEND_W-1:0];
        if (i_flush)
            w_cnt_nxt = '0;
        else if (w_under)
            w_cnt_nxt = '0;
        else if (w_over)
            w_cnt_nxt = MAXC;
    end

    // Data and pending-counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_wr_hit)
                r_value <= w_wr_data;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_value  = r_value;
    assign o_locked = (r_cnt != '0);
    // Flush-cycle decrements are thrown away, so they cannot raise an error.
    assign o_err    = !i_flush && (w_under || w_over);
endmodule

// Top level: x1..x31 entries plus the sticky scoreboard error flag.
module riscv_regfile #(
    parameter int REGISTER_PORTS = 2,
    parameter int PEND_W         = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [REGISTER_PORTS-1:0]        register_lock_en,
    input  logic [REGISTER_PORTS-1:0][4:0]   register_lock,
    input  logic [REGISTER_PORTS-1:0]        register_write_en,
    input  logic [REGISTER_PORTS-1:0][4:0]   register_write,
    input  logic [REGISTER_PORTS-1:0][31:0]  register_write_data,
    input  logic                             flush,
    output logic [31:0][31:0]                register,
    output logic [31:0]                      register_locked,
    output logic                             sb_error
);
    logic [31:0][31:0] w_value;
    logic [31:0]       w_locked;
    logic [31:0]       w_err;
    logic              r_sb_error;

    // x0 has no storage and never reports a lock or an error.
    assign w_value[0]  = '0;
    assign w_locked[0] = 1'b0;
    assign w_err[0]    = 1'b0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        riscv_regfile_entry #(
            .IDX    (i),
            .P      (REGISTER_PORTS),
            .PEND_W (PEND_W)
        ) u_entry (
            .clock        (clock),
            .reset        (reset),
            .i_flush      (flush),
            .i_lock_en    (register_lock_en),
            .i_lock       (register_lock),
            .i_write_en   (register_write_en),
            .i_write      (register_write),
            .i_write_data (register_write_data),
            .o_value      (w_value[i]),
            .o_locked     (w_locked[i]),
            .o_err        (w_err[i])
        );
    end

    // Sticky error: any entry over/underflow sets it until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_sb_error <= 1'b0;
        else if (|w_err)
            r_sb_error <= 1'b1;
    end

    assign register        = w_value;
    assign register_locked = w_locked;
    assign sb_error        = r_sb_error;
endmodule

// File: tb/tb_riscv_regfile.sv
// Self-checking bench for riscv_regfile: expectations are queued as stimulus is
// driven and compared once the clock edge that should produce them has passed.
module tb_riscv_regfile;
    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        lock_en;
    logic [1:0][4:0]   lk;
    logic [1:0]        wen;
    logic [1:0][4:0]   wr;
    logic [1:0][31:0]  wd;
    logic              flush;
    logic [31:0][31:0] register;
    logic [31:0]       locked;
    logic              sb_error;

    typedef struct {
        string       name;
        int          kind;   // 0 reg value, 1 locked bit, 2 sb_error, 3 full locked vector
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    riscv_regfile #(.REGISTER_PORTS(2), .PEND_W(2)) dut (
        .clock               (clock),
        .reset               (reset),
        .register_lock_en    (lock_en),
        .register_lock       (lk),
        .register_write_en   (wen),
        .register_write      (wr),
        .register_write_data (wd),
        .flush               (flush),
        .register            (register),
        .register_locked     (locked),
        .sb_error            (sb_error)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] obs(input int kind, input int idx);
        case (kind)
            0:       obs = register[idx];
            1:       obs = {31'b0, locked[idx]};
            2:       obs = {31'b0, sb_error};
            default: obs = locked;
        endcase
    endfunction

    task automatic push(input string n, input int k, input int i, input logic [31:0] v);
        sbq.push_back('{n, k, i, v});
    endtask

    task automatic idle();
        lock_en = '0; lk = '0; wen = '0; wr = '0; wd = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        tick();
        push("rst_reg0", 0, 0, 32'h0);
        push("rst_reg5", 0, 5, 32'h0);
        push("rst_reg31", 0, 31, 32'h0);
        push("rst_locked", 3, 0, 32'h0);
        push("rst_sberr", 2, 0, 32'h0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); checks++;
            if (obs(e.kind, e.idx) !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
            end
        end
    endtask

    task automatic test_lock_write();
        for (int s = 0; s < 5; s++) begin
            idle();
            case (s)
                0: begin lock_en = 2'b01; lk[0] = 5'd5;
                         push("lw_lock5_c1", 1, 5, 1); push("lw_reg5_old", 0, 5, 0); end
                1, 2: push("lw_lock5_hold", 1, 5, 1);
                3: begin wen = 2'b01; wr[0] = 5'd5; wd[0] = 32'hDEADBEEF;
                         push("lw_lock5_c4", 1, 5, 0); push("lw_reg5", 0, 5, 32'hDEADBEEF); end
                default: begin push("lw_reg5_keep", 0, 5, 32'hDEADBEEF);
                         push("lw_sberr", 2, 0, 0); end
            endcase
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (obs(e.kind, e.idx) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
                end
            end
        end
    endtask

    task automatic test_double_lock();
        for (int s = 0; s < 3; s++) begin
            idle();
            case (s)
                0: begin lock_en = 2'b11; lk[0] = 5'd7; lk[1] = 5'd7;
                         push("dl_lock7", 1, 7, 1); end
                1: begin wen = 2'b01; wr[0] = 5'd7; wd[0] = 32'h77;
                         push("dl_lock7_one_left", 1, 7, 1); push("dl_reg7_a", 0, 7, 32'h77); end
                default: begin wen = 2'b10; wr[1] = 5'd7; wd[1] = 32'h78;
                         push("dl_lock7_clear", 1, 7, 0); push("dl_reg7_b", 0, 7, 32'h78);
                         push("dl_sberr", 2, 0, 0); end
            endcase
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (obs(e.kind, e.idx) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 5; s++) begin
            idle();
            case (s)
                0: begin lock_en = 2'b11; lk[0] = 5'd9; lk[1] = 5'd9;
                         push("bb_lock9", 1, 9, 1); end
                1: begin wen = 2'b11; wr[0] = 5'd9; wr[1] = 5'd9;
                         wd[0] = 32'h11; wd[1] = 32'h22;
                         push("bb_reg9_p1_wins", 0, 9, 32'h22); push("bb_lock9_clear", 1, 9, 0); end
                2: begin lock_en = 2'b01; lk[0] = 5'd12;
                         push("bb_lock12", 1, 12, 1); end
                3: begin lock_en = 2'b10; lk[1] = 5'd12; wen = 2'b01; wr[0] = 5'd12;
                         wd[0] = 32'h12;
                         push("bb_lock12_net", 1, 12, 1); push("bb_reg12", 0, 12, 32'h12); end
                default: begin wen = 2'b10; wr[1] = 5'd12; wd[1] = 32'h13;
                         push("bb_lock12_clear", 1, 12, 0); push("bb_sberr", 2, 0, 0); end
            endcase
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (obs(e.kind, e.idx) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
                end
            end
        end
    endtask

    task automatic test_x0_flush();
        for (int s = 0; s < 4; s++) begin
            idle();
            case (s)
                0: begin lock_en = 2'b01; lk[0] = 5'd0; wen = 2'b10; wr[1] = 5'd0;
                         wd[1] = 32'hFFFF;
                         push("x0_reg0", 0, 0, 0); push("x0_locked_vec", 3, 0, 0);
                         push("x0_sberr", 2, 0, 0); end
                1: begin lock_en = 2'b11; lk[0] = 5'd1; lk[1] = 5'd2;
                         push("fl_locked_1_2", 3, 0, 32'h6); end
                2: begin flush = 1'b1; lock_en = 2'b01; lk[0] = 5'd4;
                         wen = 2'b11; wr[0] = 5'd1; wd[0] = 32'h5; wr[1] = 5'd6; wd[1] = 32'h66;
                         push("fl_locked_vec", 3, 0, 0); push("fl_reg1", 0, 1, 32'h5);
                         push("fl_reg6", 0, 6, 32'h66); push("fl_sberr", 2, 0, 0); end
                default: push("fl_lock4_dropped", 3, 0, 0);
            endcase
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (obs(e.kind, e.idx) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
                end
            end
        end
    endtask

    task automatic test_underflow();
        for (int s = 0; s < 2; s++) begin
            idle();
            if (s == 0) begin
                wen = 2'b10; wr[1] = 5'd3; wd[1] = 32'h33;
                push("uf_reg3", 0, 3, 32'h33); push("uf_lock3", 1, 3, 0);
                push("uf_sberr", 2, 0, 1);
            end else begin
                push("uf_sberr_sticky", 2, 0, 1);
            end
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (obs(e.kind, e.idx) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        idle();
        lock_en = 2'b01; lk[0] = 5'd10;
        @(negedge clock);
        reset = 1'b0;
        #1;
        push("mr_reg9", 0, 9, 0); push("mr_reg5", 0, 5, 0);
        push("mr_locked_vec", 3, 0, 0); push("mr_sberr", 2, 0, 0);
        tick();
        push("mr_lock_lost", 3, 0, 0);
        reset = 1'b1;
        idle();
        tick();
        push("mr_after_release", 3, 0, 0);
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); checks++;
            if (obs(e.kind, e.idx) !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
            end
        end
    endtask

    task automatic test_overflow();
        for (int s = 0; s < 7; s++) begin
            idle();
            if (s < 4) begin
                lock_en = 2'b01; lk[0] = 5'd3;
                push("of_lock3", 1, 3, 1);
                push("of_sberr", 2, 0, (s == 3) ? 32'h1 : 32'h0);
            end else begin
                wen = 2'b01; wr[0] = 5'd3; wd[0] = 32'(s);
                push("of_drain_lock3", 1, 3, (s == 6) ? 32'h0 : 32'h1);
                push("of_sberr_sticky", 2, 0, 1);
            end
            tick();
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (obs(e.kind, e.idx) !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(e.kind, e.idx), e.val);
                end
            end
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        test_reset();
        test_lock_write();
        test_double_lock();
        test_back_to_back();
        test_x0_flush();
        test_underflow();
        test_mid_reset();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
